// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump transmitter.
package reg_dump_pkg;

   localparam int unsigned IDX_W         = 5;
   localparam int unsigned CNT_W         = 2;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BYTES_PER_REG = 4;

   localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      SEND,
      CHK,
      FIN
   } state_t;

endpackage

// File: rtl/reg_dump_tx.sv
// Walks the register file through its read port and streams a framed byte dump
// (header, MSB-first register bytes, XOR checksum) over a valid/ready interface.
module reg_dump_tx
   import reg_dump_pkg::*;
#(
   parameter int unsigned       NUM_REGS = 32,
   parameter logic [BYTE_W-1:0] HEADER   = HEADER_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [IDX_W-1:0]  reg_addr,
   input  logic [WORD_W-1:0] reg_data,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_REG - 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [BYTE_W-1:0]   r_chk;
   logic [WORD_W-1:0]   r_shift;

   // tx_data always holds the byte on offer, so it is loaded one step ahead
   // of each handshake; reg_addr moves only when entering LOAD.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_chk    <= '0;
         r_shift  <= '0;
         reg_addr <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx    <= '0;
                  r_cnt    <= '0;
                  r_chk    <= '0;
                  tx_data  <= HEADER;
                  tx_valid <= 1'b1;
                  busy     <= 1'b1;
                  r_state  <= HDR;
               end
            end
            HDR: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  reg_addr <= r_idx;
                  r_state  <= LOAD;
               end
            end
            LOAD: begin
               r_shift  <= reg_data;
               tx_data  <= reg_data[WORD_W-1 -: BYTE_W];
               tx_valid <= 1'b1;
               r_cnt    <= '0;
               r_state  <= SEND;
            end
            SEND: begin
               if (tx_ready) begin
                  r_chk   <= r_chk ^ tx_data;
                  r_shift <= r_shift << BYTE_W;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_BYTE) begin
                     if (r_idx == LAST_IDX) begin
                        // Fold in the byte being accepted now.
                        tx_data <= r_chk ^ tx_data;
                        r_state <= CHK;
                     end else begin
                        r_idx    <= r_idx + IDX_W'(1);
                        reg_addr <= r_idx + IDX_W'(1);
                        tx_valid <= 1'b0;
                        r_state  <= LOAD;
                     end
                  end else begin
                     tx_data <= r_shift[WORD_W-BYTE_W-1 -: BYTE_W];
                  end
               end
            end
            CHK: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= FIN;
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: cycle-exact table for one dump plus frame-level
// sequences for backpressure, live updates, ignored start and mid-frame reset.
module tb_reg_dump_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   logic [31:0] regs [32];
   logic [7:0]  got  [256];
   int          nbytes;
   int          ndone;
   int          done_cyc;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign reg_data = regs[reg_addr];

   reg_dump_tx #(.NUM_REGS(32), .HEADER(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .reg_addr (reg_addr),
      .reg_data (reg_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      int         cyc;
      logic       v;
      logic [7:0] d;
      logic       b;
      logic       dn;
      logic       ca;
      logic [4:0] a;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Pulse start and collect the accepted byte stream until done.
   task automatic run_frame(input int ready_pct, input bit live, input bit mid_start,
                            input int exp_done);
      int         cyc;
      bit         pend;
      bit         r;
      bit         busy_ok;
      logic [7:0] pdata;
      nbytes = 0; ndone = 0; done_cyc = -1; busy_ok = 1; pend = 0; pdata = '0;
      start = 1'b1;
      tx_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (ndone == 0 && cyc < 3000) begin
         if (pend) begin
            chk($sformatf("hold_valid_c%0d", cyc), 32'(tx_valid), 32'd1);
            chk($sformatf("hold_data_c%0d", cyc), 32'(tx_data), 32'(pdata));
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            if (busy) busy_ok = 0;
         end else if (!busy) begin
            busy_ok = 0;
         end
         if (live && reg_addr == 5'd3 && tx_valid) regs[5] = 32'h12345678;
         start = (mid_start && cyc == 50);
         r = ($urandom_range(0, 99) < ready_pct);
         tx_ready = r;
         if (tx_valid && r && nbytes < 256) begin
            got[nbytes] = tx_data;
            nbytes++;
         end
         pend  = tx_valid && !r;
         pdata = tx_data;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      tx_ready = 1'b1;
      chk("done_seen", 32'(ndone), 32'd1);
      chk("busy_profile", 32'(busy_ok), 32'd1);
      if (exp_done > 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("post_done_%0d", i), 32'(done), 32'd0);
         chk($sformatf("post_valid_%0d", i), 32'(tx_valid), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // Compare the collected stream against a frame built from the register model.
   task automatic cmp_frame(input string nm);
      logic [7:0] exp [130];
      logic [7:0] x;
      x = 8'h00;
      exp[0] = 8'hA5;
      for (int r = 0; r < 32; r++) begin
         for (int b = 0; b < 4; b++) begin
            exp[1 + 4*r + b] = regs[r][31 - 8*b -: 8];
            x ^= regs[r][31 - 8*b -: 8];
         end
      end
      exp[129] = x;
      chk({nm, "_len"}, 32'(nbytes), 32'd130);
      for (int i = 0; i < 130 && i < nbytes; i++)
         chk($sformatf("%s_byte%0d", nm, i), 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[2] = 32'hC0000602;
      regs[3] = 32'd3;
      for (int i = 4; i <= 16; i++) regs[i] = 32'(i);

      tbl[0]  = '{1,   1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[1]  = '{2,   1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0};
      tbl[2]  = '{3,   1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[3]  = '{6,   1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[4]  = '{7,   1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1};
      tbl[5]  = '{12,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd2};
      tbl[6]  = '{13,  1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[7]  = '{14,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[8]  = '{15,  1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[9]  = '{16,  1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[10] = '{17,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd3};
      tbl[11] = '{21,  1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[12] = '{22,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd4};
      tbl[13] = '{26,  1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[14] = '{157, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd31};
      tbl[15] = '{161, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[16] = '{162, 1'b1, 8'hD7, 1'b1, 1'b0, 1'b0, 5'd0};
      tbl[17] = '{163, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0};
      tbl[18] = '{164, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};

      // Reset state
      rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_addr",  32'(reg_addr), 32'd0);
      chk("rst_data",  32'(tx_data),  32'd0);
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy",  32'(busy),     32'd0);
      chk("rst_done",  32'(done),     32'd0);

      // Cycle-exact table with tx_ready tied high
      start = 1'b1; tx_ready = 1'b1;
      begin
         int k;
         k = 0;
         for (int c = 1; c <= 164; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k < 19 && tbl[k].cyc == c) begin
               chk($sformatf("tbl_c%0d_valid", c), 32'(tx_valid), 32'(tbl[k].v));
               chk($sformatf("tbl_c%0d_busy", c),  32'(busy),     32'(tbl[k].b));
               chk($sformatf("tbl_c%0d_done", c),  32'(done),     32'(tbl[k].dn));
               if (tbl[k].v)  chk($sformatf("tbl_c%0d_data", c), 32'(tx_data),  32'(tbl[k].d));
               if (tbl[k].ca) chk($sformatf("tbl_c%0d_addr", c), 32'(reg_addr), 32'(tbl[k].a));
               k++;
            end
         end
         chk("tbl_all_applied", 32'(k), 32'd19);
      end
      repeat (3) @(posedge clk); #1;

      // Full frame, ready high
      run_frame(100, 1'b0, 1'b0, 163);
      cmp_frame("full");

      // Backpressure, ~30% ready
      run_frame(30, 1'b0, 1'b0, 0);
      cmp_frame("bp");

      // Live update of reg5 during reg3
      run_frame(100, 1'b1, 1'b0, 163);
      chk("live_b0", 32'(got[21]), 32'h12);
      chk("live_b1", 32'(got[22]), 32'h34);
      chk("live_b2", 32'(got[23]), 32'h56);
      chk("live_b3", 32'(got[24]), 32'h78);
      cmp_frame("live");
      regs[5] = 32'd5;

      // Start pulse while busy is ignored
      run_frame(100, 1'b0, 1'b1, 163);
      cmp_frame("ign");

      // Reset during SEND of reg10, with a byte pending
      start = 1'b1; tx_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (!(reg_addr == 5'd10 && tx_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
         end
         chk("reach_reg10", 32'(n < 300), 32'd1);
      end
      rst_n = 1'b0; tx_ready = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(tx_valid), 32'd0);
      chk("midrst_busy",  32'(busy),     32'd0);
      chk("midrst_done",  32'(done),     32'd0);
      chk("midrst_addr",  32'(reg_addr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(100, 1'b0, 1'b0, 163);
      cmp_frame("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Register-file dump transmitter for the pipeline debug path. On a start request it walks the instruction-decode register file through a read-address port, one register at a time, and streams each 32-bit value out as bytes over a valid/ready byte interface feeding the debug UART transmitter. It frames the stream with a header byte and an XOR checksum trailer. It is the reading end of the register file's debug view: the register file writes and holds the values, and this block reads and exports them.

## Interface
Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1)
- HEADER, 8'hA5, first byte of every dump frame

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  dump request; sampled only in IDLE
- reg_addr  out  5  register index presented to the register file read port
- reg_data  in  32  value of register[reg_addr], combinational from the register file
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte this cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the checksum byte is accepted

## Operation
- FSM states: IDLE, HDR, LOAD, SEND, CHK, FIN.
- IDLE: busy=0, tx_valid=0. When start=1, clear idx, byte count and checksum, then go to HDR.
- HDR: tx_valid=1, tx_data=HEADER. On handshake, go to LOAD. The header is not included in the checksum.
- LOAD: reg_addr=idx. Capture reg_data into a 32-bit shift register, clear byte count, then go to SEND. tx_valid=0.
- SEND: tx_valid=1, tx_data=shift[31:24], so registers go out MSB first. On each handshake:
  - checksum ^= tx_data
  - shift <<= 8
  - byte count++
  - On the 4th byte: if idx==NUM_REGS-1 go to CHK, else idx++ and go to LOAD.
- CHK: tx_valid=1, tx_data=checksum, the XOR of all 4*NUM_REGS data bytes. On handshake, go to FIN.
- FIN: done=1 and busy=0 for one cycle, then go to IDLE.
- Handshake rule: a byte transfers only on a cycle with tx_valid&tx_ready. While tx_valid=1 and tx_ready=0, tx_data and state hold.
- start while busy is ignored. start held high across FIN begins a new dump from IDLE on the following cycle.
- Snapshot semantics: each register is sampled at its own LOAD cycle. The dump is not atomic across registers; writes landing between LOADs are reflected.
- Widths: idx is 5 bits, byte count 2 bits and wraps naturally, checksum 8 bits.

## Timing
- All outputs are registered.
- Reset values: reg_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE, checksum=0.
- Reset asserted mid-dump: on the next edge the block returns to IDLE with tx_valid=0, even if a byte was pending. This is the only permitted drop of tx_valid without a handshake.
- Latency with tx_ready tied high, start at cycle 0:
  - header valid at cycle 1
  - LOAD at cycle 2
  - reg 0 bytes at cycles 3-6
  - LOAD for reg 1 at cycle 7, and so on (5 cycles per register)
  - checksum valid at cycle 1+5*NUM_REGS+1 = 162
  - done at cycle 163
- Total frame: 4*NUM_REGS+2 = 130 bytes.
- reg_addr changes only on entry to LOAD, so reg_data has a full cycle of setup.

## Structure
- Package reg_dump_pkg holds:
  - state enum (IDLE, HDR, LOAD, SEND, CHK, FIN)
  - HEADER default constant
  - BYTES_PER_REG=4 constant
- Single module with no sub-module. The FSM, shift register and checksum are small enough to stay together.

## Test plan
- Reset state: rst_n=0 for 2 cycles, then release with start=0 -> all outputs at reset values, state IDLE, no tx_valid.
- Full dump, tx_ready=1: register model holds reg2=32'hC0000602, reg3=3, regN=N for N in 4..16, others 0. Pulse start -> 130 bytes in order:
  - A5, 00 00 00 00 (reg0), 00 00 00 00 (reg1), C0 00 06 02 (reg2), 00 00 00 03 (reg3), ...
  - last byte = XOR of all data bytes
  - done pulses exactly once at cycle 163
- Backpressure: drive tx_ready with a random 30% duty -> byte sequence identical to the previous scenario; tx_data never changes while tx_valid&!tx_ready.
- Live update: change reg5 from 5 to 32'h12345678 while the block is in SEND for reg3 -> reg5 bytes are 12 34 56 78 and the checksum matches them.
- Start ignored while busy: pulse start at cycle 50 of a dump -> exactly one frame of 130 bytes, busy never deasserts early.
- Reset mid-frame: assert rst_n=0 during SEND of reg10 -> tx_valid=0 on the next edge. A subsequent start yields a fresh frame beginning with A5 and a checksum computed only over the new frame.
